// File: rtl/sb_reinject_unit_pkg.sv
// Shared defaults, channel direction codes and the flit type for the
// side-buffer reinjection unit.
package sb_pkg;
  localparam int DEF_FLIT_W = 11;
  localparam int DEF_NCH    = 4;

  localparam int DIR_E = 0;
  localparam int DIR_W = 1;
  localparam int DIR_N = 2;
  localparam int DIR_S = 3;

  typedef logic [DEF_FLIT_W-1:0] flit_t;
endpackage

// File: rtl/sb_reinject_unit_if.sv
// Channel, side-buffer offer and status bundle between the input latches,
// the reinjection unit and the permutation stage.
interface sb_reinject_unit_if
  import sb_pkg::*;
#(
  parameter int FLIT_W = DEF_FLIT_W,
  parameter int NCH    = DEF_NCH,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NCH*FLIT_W-1:0] in_flit;
  logic [NCH-1:0]        in_vld;
  logic [FLIT_W-1:0]     buf_flit;
  logic                  buf_vld;
  logic                  buf_ready;
  logic [NCH*FLIT_W-1:0] out_flit;
  logic [NCH-1:0]        out_vld;
  logic [CW-1:0]         count;
  logic                  redir;

  modport master (
    output in_flit, in_vld, buf_flit, buf_vld,
    input  buf_ready, out_flit, out_vld, count, redir
  );

  modport slave (
    input  in_flit, in_vld, buf_flit, buf_vld,
    output buf_ready, out_flit, out_vld, count, redir
  );
endinterface

// File: rtl/sb_reinject_unit_fifo.sv
// Side-buffer FIFO; occupancy is tracked by count so a full FIFO can
// still push and pop in the same cycle.
module sb_fifo
  import sb_pkg::*;
#(
  parameter int FLIT_W = DEF_FLIT_W,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_flit,
  input  logic              pop,
  output logic [FLIT_W-1:0] head,
  output logic [CW-1:0]     count
);
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd;
  logic [AW-1:0]     wr;

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= push_flit;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd];
endmodule

// File: rtl/sb_reinject_unit.sv
// Reinjects buffered deflected flits into free input channels round-robin,
// and swaps out a resident flit when every channel stays busy too long.
module sb_reinject_unit
  import sb_pkg::*;
#(
  parameter int FLIT_W    = DEF_FLIT_W,
  parameter int NCH       = DEF_NCH,
  parameter int DEPTH     = 4,
  parameter int STARVE_TH = 8
) (
  input logic                clk,
  input logic                rst,
  sb_reinject_unit_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = $clog2(STARVE_TH + 1);

  logic [FLIT_W-1:0]     head;
  logic [CW-1:0]         fill;
  logic [RW-1:0]         rr;
  logic [RW-1:0]         free_idx;
  logic [RW-1:0]         sel_ch;
  logic                  free_found;
  logic [SW-1:0]         starve;
  logic                  push_acc;
  logic                  not_empty;
  logic                  inject;
  logic                  redirect;
  logic                  take;
  logic                  fifo_push;
  logic [FLIT_W-1:0]     fifo_din;
  logic [FLIT_W-1:0]     rr_flit;
  logic [NCH*FLIT_W-1:0] out_flit_q;
  logic [NCH-1:0]        out_vld_q;
  logic                  redir_q;

  function automatic logic [RW-1:0] rr_next(input logic [RW-1:0] c);
    return (int'(c) == NCH - 1) ? '0 : c + 1'b1;
  endfunction

  assign not_empty = (fill != '0);
  assign push_acc  = bus.buf_vld && bus.buf_ready;
  assign inject    = not_empty && free_found;
  assign redirect  = not_empty && !free_found && (starve == SW'(STARVE_TH)) && !push_acc;
  assign take      = inject || redirect;
  assign sel_ch    = inject ? free_idx : rr;
  assign fifo_push = push_acc || redirect;
  assign fifo_din  = redirect ? rr_flit : bus.buf_flit;

  always_comb begin
    logic [RW-1:0] idx;
    idx        = '0;
    free_found = 1'b0;
    free_idx   = rr;
    for (int k = 0; k < NCH; k++) begin
      idx = RW'((int'(rr) + k) % NCH);
      if (!free_found && !bus.in_vld[idx]) begin
        free_found = 1'b1;
        free_idx   = idx;
      end
    end
  end

  always_comb begin
    rr_flit = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rr == RW'(i)) rr_flit = bus.in_flit[i*FLIT_W +: FLIT_W];
    end
  end

  sb_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_flit (fifo_din),
    .pop       (take),
    .head      (head),
    .count     (fill)
  );

  // Channels pass through by default; the selected channel carries the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flit_q <= '0;
      out_vld_q  <= '0;
      redir_q    <= 1'b0;
      rr         <= RW'(DIR_E);
      starve     <= '0;
    end else begin
      out_flit_q <= bus.in_flit;
      out_vld_q  <= bus.in_vld;
      redir_q    <= redirect;
      for (int i = 0; i < NCH; i++) begin
        if (take && sel_ch == RW'(i)) begin
          out_flit_q[i*FLIT_W +: FLIT_W] <= head;
          out_vld_q[i]                   <= 1'b1;
        end
      end
      if (take) rr <= rr_next(sel_ch);
      if (!not_empty || take)
        starve <= '0;
      else if (starve != SW'(STARVE_TH))
        starve <= starve + 1'b1;
    end
  end

  assign bus.buf_ready = (fill < CW'(DEPTH));
  assign bus.count     = fill;
  assign bus.out_flit  = out_flit_q;
  assign bus.out_vld   = out_vld_q;
  assign bus.redir     = redir_q;
endmodule

// File: tb/tb_sb_reinject_unit.sv
// Randomised and directed scoreboard bench for sb_reinject_unit against a
// queue-based reference model.
module tb_sb_reinject_unit;
  import sb_pkg::*;

  localparam int FW = 11;
  localparam int NC = 4;
  localparam int DP = 4;
  localparam int TH = 8;

  typedef struct {
    logic [NC*FW-1:0] flit;
    logic [NC-1:0]    vld;
    int               cnt;
    logic             rdy;
    logic             rd;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  exp_t  expq[$];
  exp_t  mon_e;
  flit_t mq[$];
  int    mrr;
  int    mstarve;
  int    checks;
  int    errors;

  always #5 clk = ~clk;

  sb_reinject_unit_if #(.FLIT_W(FW), .NCH(NC), .DEPTH(DP)) bus ();

  sb_reinject_unit #(.FLIT_W(FW), .NCH(NC), .DEPTH(DP), .STARVE_TH(TH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and record what the unit must show after the edge.
  task automatic apply_stimulus(input logic [NC*FW-1:0] fl, input logic [NC-1:0] v,
                                input flit_t bf, input logic bv);
    exp_t  e;
    int    fi;
    bit    acc;
    flit_t t;
    @(negedge clk);
    bus.in_flit  = fl;
    bus.in_vld   = v;
    bus.buf_flit = bf;
    bus.buf_vld  = bv;
    e.flit = fl;
    e.vld  = v;
    e.rd   = 1'b0;
    acc    = bv && (mq.size() < DP);
    if (mq.size() > 0) begin
      fi = -1;
      for (int k = 0; k < NC; k++)
        if (fi < 0 && !v[(mrr + k) % NC]) fi = (mrr + k) % NC;
      if (fi >= 0) begin
        e.flit[fi*FW +: FW] = mq.pop_front();
        e.vld[fi] = 1'b1;
        mrr = (fi + 1) % NC;
        mstarve = 0;
      end else if (mstarve == TH && !acc) begin
        t = fl[mrr*FW +: FW];
        e.flit[mrr*FW +: FW] = mq.pop_front();
        mq.push_back(t);
        mrr = (mrr + 1) % NC;
        mstarve = 0;
        e.rd = 1'b1;
      end else if (mstarve < TH) begin
        mstarve++;
      end
    end else begin
      mstarve = 0;
    end
    if (acc) mq.push_back(bf);
    e.cnt = mq.size();
    e.rdy = (mq.size() < DP);
    expq.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.in_flit  = '0;
    bus.in_vld   = '0;
    bus.buf_flit = '0;
    bus.buf_vld  = 1'b0;
  endtask

  // Reset is raised mid-phase so its effect is visible without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    check_output("rst_count", 64'(bus.count), 64'd0);
    check_output("rst_out_vld", 64'(bus.out_vld), 64'd0);
    mq.delete();
    expq.delete();
    mrr = 0;
    mstarve = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("rst_buf_ready", 64'(bus.buf_ready), 64'd1);
    check_output("rst_redir", 64'(bus.redir), 64'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && expq.size() > 0) begin
        mon_e = expq.pop_front();
        check_output("sb_out_flit", 64'(bus.out_flit), 64'(mon_e.flit));
        check_output("sb_out_vld", 64'(bus.out_vld), 64'(mon_e.vld));
        check_output("sb_count", 64'(bus.count), 64'(mon_e.cnt));
        check_output("sb_buf_ready", 64'(bus.buf_ready), 64'(mon_e.rdy));
        check_output("sb_redir", 64'(bus.redir), 64'(mon_e.rd));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected to end by 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NC*FW-1:0] bsy;
    logic [NC*FW-1:0] rf;
    logic [NC-1:0]    rv;
    checks = 0;
    errors = 0;
    idle_inputs();
    do_reset();

    // Basic reinject into the first free channel (north).
    apply_stimulus('0, 4'b0000, 11'h05F, 1'b1);
    apply_stimulus({11'h005, 11'h000, 11'h027, 11'h421}, 4'b1011, 11'h000, 1'b0);
    settle();
    check_output("basic_ch2", 64'(bus.out_flit[2*FW +: FW]), 64'h05F);
    check_output("basic_vld", 64'(bus.out_vld), 64'hF);
    check_output("basic_count", 64'(bus.count), 64'd0);
    apply_stimulus('0, 4'b1111, 11'h7AB, 1'b1);
    apply_stimulus('0, 4'b0000, 11'h000, 1'b0);
    settle();
    check_output("basic_rr3", 64'(bus.out_flit[3*FW +: FW]), 64'h7AB);

    // Round-robin across three buffered flits.
    do_reset();
    apply_stimulus('0, 4'b1111, 11'h101, 1'b1);
    apply_stimulus('0, 4'b1111, 11'h202, 1'b1);
    apply_stimulus('0, 4'b1111, 11'h303, 1'b1);
    apply_stimulus('0, 4'b0000, 11'h000, 1'b0);
    settle();
    check_output("rr_a_ch0", 64'(bus.out_flit[0 +: FW]), 64'h101);
    check_output("rr_a_cnt", 64'(bus.count), 64'd2);
    apply_stimulus('0, 4'b0000, 11'h000, 1'b0);
    settle();
    check_output("rr_b_ch1", 64'(bus.out_flit[FW +: FW]), 64'h202);
    apply_stimulus('0, 4'b0000, 11'h000, 1'b0);
    settle();
    check_output("rr_c_ch2", 64'(bus.out_flit[2*FW +: FW]), 64'h303);
    check_output("rr_c_cnt", 64'(bus.count), 64'd0);

    // Full buffer refuses a fifth offer.
    do_reset();
    for (int i = 0; i < 4; i++) apply_stimulus('0, 4'b1111, flit_t'(11'h10 + i), 1'b1);
    settle();
    check_output("full_count", 64'(bus.count), 64'd4);
    check_output("full_ready", 64'(bus.buf_ready), 64'd0);
    apply_stimulus('0, 4'b1111, 11'h3FF, 1'b1);
    settle();
    check_output("full_hold", 64'(bus.count), 64'd4);

    // Starvation redirect swaps the head with channel 0.
    do_reset();
    bsy = {11'h444, 11'h333, 11'h222, 11'h111};
    apply_stimulus(bsy, 4'b1111, 11'h0AA, 1'b1);
    for (int i = 0; i < TH + 1; i++) apply_stimulus(bsy, 4'b1111, 11'h000, 1'b0);
    settle();
    check_output("starve_ch0", 64'(bus.out_flit[0 +: FW]), 64'h0AA);
    check_output("starve_redir", 64'(bus.redir), 64'd1);
    check_output("starve_count", 64'(bus.count), 64'd1);
    apply_stimulus(bsy, 4'b1111, 11'h000, 1'b0);
    settle();
    check_output("starve_pulse", 64'(bus.redir), 64'd0);
    apply_stimulus('0, 4'b0000, 11'h000, 1'b0);
    settle();
    check_output("starve_head", 64'(bus.out_flit[FW +: FW]), 64'h111);

    // Accepted push defers the redirect by one cycle; then reset mid-burst.
    do_reset();
    apply_stimulus(bsy, 4'b1111, 11'h0CC, 1'b1);
    for (int i = 0; i < TH; i++) apply_stimulus(bsy, 4'b1111, 11'h000, 1'b0);
    apply_stimulus(bsy, 4'b1111, 11'h0DD, 1'b1);
    settle();
    check_output("defer_redir", 64'(bus.redir), 64'd0);
    check_output("defer_count", 64'(bus.count), 64'd2);
    apply_stimulus(bsy, 4'b1111, 11'h000, 1'b0);
    settle();
    check_output("defer_fire", 64'(bus.redir), 64'd1);
    check_output("defer_ch0", 64'(bus.out_flit[0 +: FW]), 64'h0CC);
    apply_stimulus(bsy, 4'b1111, 11'h0EE, 1'b1);
    do_reset();

    // Random traffic, mostly saturated so starvation occurs.
    for (int n = 0; n < 600; n++) begin
      rf = {$urandom, $urandom};
      rv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      apply_stimulus(rf, rv, flit_t'($urandom), ($urandom_range(0, 2) == 0));
      if (n == 300) do_reset();
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    check_output("drain", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
